// File: rtl/input_controller_if.sv
// Bundle between the ADC capture path, the write side of the dual-clock FIFO
// and the host status bits. The controller sits on the master side.
interface input_controller_if #(
  parameter int DATA_WIDTH  = 11,
  parameter int LEVEL_WIDTH = 4,
  parameter int DROP_WIDTH  = 8
);
  logic                   enable;
  logic                   adc_start;
  logic [DATA_WIDTH-1:0]  adc_data;
  logic                   adc_valid;
  logic [LEVEL_WIDTH-1:0] fifo_level;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   fifo_write_irq;
  logic                   fifo_write_clock;
  logic                   overflow;
  logic                   overflow_clear;
  logic [DROP_WIDTH-1:0]  drop_count;
  logic                   busy;
  logic [1:0]             dbg_state;

  // adc_valid is a one-cycle strobe with no back-pressure: the controller
  // either takes the sample on that edge or counts it as dropped.
  modport master (
    input  enable, adc_data, adc_valid, fifo_level, overflow_clear,
    output adc_start, fifo_data, fifo_write_irq, fifo_write_clock,
           overflow, drop_count, busy, dbg_state
  );

  modport slave (
    output enable, adc_data, adc_valid, fifo_level, overflow_clear,
    input  adc_start, fifo_data, fifo_write_irq, fifo_write_clock,
           overflow, drop_count, busy, dbg_state
  );
endinterface

// File: rtl/input_controller.sv
// Captures ADC samples into a one-entry hold register and writes them into the
// dual-clock FIFO with a locally generated write clock; paces adc_start.
module input_controller #(
  parameter int DATA_WIDTH    = 11,
  parameter int LEVEL_WIDTH   = 4,
  parameter int FULL_LEVEL    = 15,
  parameter int SAMPLE_PERIOD = 40,
  parameter int DROP_WIDTH    = 8
) (
  input logic               clock,
  input logic               reset_n,
  input_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [15:0]          LAST_COUNT = 16'(SAMPLE_PERIOD - 1);
  localparam logic [LEVEL_WIDTH:0] FULL_MARK  = (LEVEL_WIDTH+1)'(FULL_LEVEL);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX  = '1;

  state_t                 state_q;
  logic [15:0]            count_q, count_d;
  logic                   start_q;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic                   hold_valid_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   irq_q;
  logic                   wclk_q;
  logic                   busy_q;
  logic                   overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;

  logic room;
  logic transfer;
  logic write_go;
  logic capture;
  logic drop_new;
  logic drop_evt;
  logic start_d;

  always_comb begin
    room     = {1'b0, bus.fifo_level} < FULL_MARK;
    // The hold register is vacated in IDLE whether the sample is written or
    // refused for lack of room, so a capture on that edge is always accepted.
    transfer = (state_q == S_IDLE) && hold_valid_q;
    write_go = transfer && room;
    capture  = bus.enable && bus.adc_valid;
    drop_new = capture && hold_valid_q && !transfer;
    drop_evt = drop_new || (transfer && !room);

    count_d = 16'd0;
    start_d = 1'b0;
    if (bus.enable) begin
      start_d = (count_q == LAST_COUNT);
      count_d = (count_q == LAST_COUNT) ? 16'd0 : count_q + 16'd1;
    end

    overflow_d = overflow_q;
    drop_d     = drop_q;
    // A drop on the same edge as a clear survives the clear.
    if (bus.overflow_clear) begin
      overflow_d = drop_evt;
      drop_d     = drop_evt ? DROP_WIDTH'(1) : '0;
    end else if (drop_evt) begin
      overflow_d = 1'b1;
      drop_d     = (drop_q == DROP_MAX) ? drop_q : drop_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= 16'd0;
      start_q      <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      data_q       <= '0;
      irq_q        <= 1'b0;
      wclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      count_q    <= count_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;

      if (capture && !drop_new) begin
        hold_q       <= bus.adc_data;
        hold_valid_q <= 1'b1;
      end else if (transfer) begin
        hold_valid_q <= 1'b0;
      end

      // Data and request lead the write-clock rise by a full cycle so the
      // FIFO sees them settled on its own clock edge.
      case (state_q)
        S_IDLE: begin
          if (write_go) begin
            data_q  <= hold_q;
            irq_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          wclk_q  <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          wclk_q  <= 1'b0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.adc_start        = start_q;
  assign bus.fifo_data        = data_q;
  assign bus.fifo_write_irq   = irq_q;
  assign bus.fifo_write_clock = wclk_q;
  assign bus.overflow         = overflow_q;
  assign bus.drop_count       = drop_q;
  assign bus.busy             = busy_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller: start cadence, write sequencing,
// drop accounting and asynchronous reset behaviour.
module tb_input_controller;
  localparam int W = 11;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   wr_count;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  input_controller_if #(.DATA_WIDTH(11), .LEVEL_WIDTH(4), .DROP_WIDTH(8)) bus ();

  input_controller #(
    .DATA_WIDTH(11), .LEVEL_WIDTH(4), .FULL_LEVEL(15),
    .SAMPLE_PERIOD(40), .DROP_WIDTH(8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // write monitor: what the FIFO latches on each write-clock rise
  always @(posedge bus.fifo_write_clock) begin
    got_q.push_back(bus.fifo_data);
    wr_count++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.enable = 1'b1;
    ticks(5);
    checks++; if (bus.adc_start !== 1'b0) begin errors++; $display("FAIL rst_adc_start got %b exp 0", bus.adc_start); end
    checks++; if (bus.fifo_data !== 11'h000) begin errors++; $display("FAIL rst_fifo_data got %h exp 000", bus.fifo_data); end
    checks++; if (bus.fifo_write_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.fifo_write_irq); end
    checks++; if (bus.fifo_write_clock !== 1'b0) begin errors++; $display("FAIL rst_wclk got %b exp 0", bus.fifo_write_clock); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop_count got %0d exp 0", bus.drop_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    reset_n = 1'b1;
    for (int k = 1; k <= 81; k++) begin
      tick();
      checks++;
      if (bus.adc_start !== ((k == 40) || (k == 80))) begin
        errors++;
        $display("FAIL start_cadence edge %0d got %b exp %b", k, bus.adc_start, (k == 40) || (k == 80));
      end
    end
  endtask

  task automatic test_single_write();
    int wr0;
    got_q.delete();
    wr0 = wr_count;
    bus.fifo_level = 4'd0;
    bus.adc_data = 11'h5A5;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    bus.adc_data = 11'h000;
    checks++; if (bus.fifo_write_irq !== 1'b0) begin errors++; $display("FAIL sw_irq_n got %b exp 0", bus.fifo_write_irq); end
    tick();
    checks++; if (bus.fifo_write_irq !== 1'b1) begin errors++; $display("FAIL sw_irq_n1 got %b exp 1", bus.fifo_write_irq); end
    checks++; if (bus.fifo_data !== 11'h5A5) begin errors++; $display("FAIL sw_data_n1 got %h exp 5a5", bus.fifo_data); end
    checks++; if (bus.fifo_write_clock !== 1'b0) begin errors++; $display("FAIL sw_wclk_n1 got %b exp 0", bus.fifo_write_clock); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sw_busy_n1 got %b exp 1", bus.busy); end
    tick();
    checks++; if (bus.fifo_write_clock !== 1'b1) begin errors++; $display("FAIL sw_wclk_n2 got %b exp 1", bus.fifo_write_clock); end
    checks++; if (bus.fifo_write_irq !== 1'b1) begin errors++; $display("FAIL sw_irq_n2 got %b exp 1", bus.fifo_write_irq); end
    tick();
    checks++; if (bus.fifo_write_clock !== 1'b0) begin errors++; $display("FAIL sw_wclk_n3 got %b exp 0", bus.fifo_write_clock); end
    checks++; if (bus.fifo_write_irq !== 1'b1) begin errors++; $display("FAIL sw_irq_n3 got %b exp 1", bus.fifo_write_irq); end
    tick();
    checks++; if (bus.fifo_write_irq !== 1'b0) begin errors++; $display("FAIL sw_irq_n4 got %b exp 0", bus.fifo_write_irq); end
    checks++; if (bus.fifo_data !== 11'h5A5) begin errors++; $display("FAIL sw_data_held got %h exp 5a5", bus.fifo_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sw_busy_n4 got %b exp 0", bus.busy); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL sw_drop_count got %0d exp 0", bus.drop_count); end
    checks++; if (wr_count - wr0 !== 1) begin errors++; $display("FAIL sw_pulses got %0d exp 1", wr_count - wr0); end
    exp_q.delete();
    exp_q.push_back(11'h5A5);
    checks++;
    if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL sw_written got %p exp %p", got_q, exp_q);
    end
  endtask

  task automatic test_enable_gate();
    int wr0;
    logic seen_start;
    wr0 = wr_count;
    seen_start = 1'b0;
    bus.enable = 1'b0;
    tick();
    bus.adc_data = 11'h7FF;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (bus.adc_start === 1'b1) seen_start = 1'b1;
    end
    checks++; if (seen_start !== 1'b0) begin errors++; $display("FAIL en_no_start got %b exp 0", seen_start); end
    checks++; if (wr_count - wr0 !== 0) begin errors++; $display("FAIL en_no_write got %0d exp 0", wr_count - wr0); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL en_no_drop got %0d exp 0", bus.drop_count); end
    bus.enable = 1'b1;
  endtask

  task automatic test_full_fifo();
    int wr0;
    wr0 = wr_count;
    bus.fifo_level = 4'd15;
    for (int i = 0; i < 3; i++) begin
      bus.adc_data = 11'(i + 16);
      bus.adc_valid = 1'b1;
      tick();
      bus.adc_valid = 1'b0;
      ticks(9);
    end
    ticks(3);
    checks++; if (wr_count - wr0 !== 0) begin errors++; $display("FAIL full_pulses got %0d exp 0", wr_count - wr0); end
    checks++; if (bus.drop_count !== 8'd3) begin errors++; $display("FAIL full_drop_count got %0d exp 3", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %b exp 1", bus.overflow); end
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL full_clr_count got %0d exp 0", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_clr_overflow got %b exp 0", bus.overflow); end
    bus.fifo_level = 4'd0;
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(11'd1);
    exp_q.push_back(11'd2);
    for (int v = 1; v <= 3; v++) begin
      bus.adc_data = 11'(v);
      bus.adc_valid = 1'b1;
      tick();
    end
    bus.adc_valid = 1'b0;
    ticks(12);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i < got_q.size() && got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_order idx %0d got %h exp %h", i, got_q[i], exp_q[i]);
      end else if (i >= got_q.size()) begin
        errors++; $display("FAIL b2b_order idx %0d got none exp %h", i, exp_q[i]);
      end
    end
    checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL b2b_drop_count got %0d exp 1", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow got %b exp 1", bus.overflow); end
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
  endtask

  task automatic test_saturation();
    int wr0;
    wr0 = wr_count;
    bus.fifo_level = 4'd15;
    bus.adc_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.adc_data = 11'($urandom_range(0, 2047));
      tick();
    end
    checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b exp 1", bus.overflow); end
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    bus.adc_valid = 1'b0;
    checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL race_count got %0d exp 1", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL race_overflow got %b exp 1", bus.overflow); end
    tick();
    checks++; if (bus.drop_count !== 8'd2) begin errors++; $display("FAIL held_drop got %0d exp 2", bus.drop_count); end
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL sat_clr_count got %0d exp 0", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sat_clr_overflow got %b exp 0", bus.overflow); end
    bus.fifo_level = 4'd0;
    ticks(4);
    checks++; if (wr_count - wr0 !== 0) begin errors++; $display("FAIL sat_no_write got %0d exp 0", wr_count - wr0); end
  endtask

  task automatic test_reset_mid_write();
    int wr0;
    bus.fifo_level = 4'd0;
    bus.adc_data = 11'h3C3;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    ticks(2);
    checks++; if (bus.fifo_write_clock !== 1'b1) begin errors++; $display("FAIL mid_wclk_high got %b exp 1", bus.fifo_write_clock); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.fifo_write_clock !== 1'b0) begin errors++; $display("FAIL mid_wclk_low got %b exp 0", bus.fifo_write_clock); end
    checks++; if (bus.fifo_write_irq !== 1'b0) begin errors++; $display("FAIL mid_irq_low got %b exp 0", bus.fifo_write_irq); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
    got_q.delete();
    wr0 = wr_count;
    bus.adc_data = 11'h1AB;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    ticks(6);
    checks++; if (wr_count - wr0 !== 1) begin errors++; $display("FAIL post_pulses got %0d exp 1", wr_count - wr0); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 11'h1AB) begin
      errors++; $display("FAIL post_data got %p exp 1ab", got_q);
    end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL post_drop got %0d exp 0", bus.drop_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_count = 0;
    reset_n = 1'b1;
    bus.enable = 1'b0;
    bus.adc_data = '0;
    bus.adc_valid = 1'b0;
    bus.fifo_level = '0;
    bus.overflow_clear = 1'b0;
    #2;
    test_reset();
    test_single_write();
    ticks(3);
    test_enable_gate();
    test_full_fifo();
    ticks(3);
    test_back_to_back();
    ticks(3);
    test_saturation();
    ticks(3);
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
